// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Optional checksum support is selected with INSTR_LOADER_CHKSUM_EN.
package instr_loader_pkg;

  localparam int INSTR_W   = 32;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/instr_chksum.sv
// Wrapping 32-bit sum of every word the loader accepts since reset.
// Only instantiated when INSTR_LOADER_CHKSUM_EN is defined.
module instr_chksum
  import instr_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               add,
  input  logic [INSTR_W-1:0] word,
  output logic [INSTR_W-1:0] sum
);

  // Accumulate accepted words; overflow past 32 bits simply wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + word;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a program from a host into instruction memory, then starts the CPU.
// Define INSTR_LOADER_CHKSUM_EN to add chksum_i / chksum_err_o and verify the
// program sum before releasing the CPU.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_valid_i,
  output logic               load_ready_o,
  input  logic [INSTR_W-1:0] load_data_i,
  input  logic               load_last_i,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [INSTR_W-1:0] wr_data_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               overflow_o,
  output logic [ADDR_W:0]    count_o
`ifdef INSTR_LOADER_CHKSUM_EN
  ,
  input  logic [INSTR_W-1:0] chksum_i,
  output logic               chksum_err_o
`endif
);

  // Address of the final memory word; a non-last word landing here overflows.
  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              at_top;
  logic              ovf_set;
  logic              chk_ok;

  assign load_ready_o = (state == ST_IDLE) || (state == ST_LOAD);
  assign xfer         = load_valid_i && load_ready_o;
  assign at_top       = (addr == TOP_ADDR);
  assign busy_o       = (state == ST_LOAD) || (state == ST_DRAIN);
  assign start_o      = (state == ST_RUN);

`ifdef INSTR_LOADER_CHKSUM_EN
  logic [INSTR_W-1:0] sum;

  instr_chksum u_chksum (
    .clk   (clk_i),
    .rst_n (rst_i),
    .add   (xfer),
    .word  (load_data_i),
    .sum   (sum)
  );

  // By DRAIN the accumulator already holds the last word.
  assign chk_ok = (sum == chksum_i);

  // Sticky checksum error, raised when DRAIN sees a mismatching sum.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      chksum_err_o <= 1'b0;
    end else if ((state == ST_DRAIN) && !chk_ok) begin
      chksum_err_o <= 1'b1;
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RUN and ERR are terminal until reset.
  always_comb begin
    state_nxt = state;
    ovf_set   = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          if (load_last_i) begin
            state_nxt = ST_DRAIN;
          end else if (at_top) begin
            state_nxt = ST_ERR;
            ovf_set   = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_DRAIN: state_nxt = chk_ok ? ST_RUN : ST_ERR;
      ST_RUN:   state_nxt = ST_RUN;
      ST_ERR:   state_nxt = ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Write pipeline: register each accepted word with its address, one cycle later.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr       <= '0;
      wr_en_o    <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      wr_en_o <= xfer;
      if (xfer) begin
        wr_addr_o <= addr;
        wr_data_o <= load_data_i;
        addr      <= addr + ADDR_W'(1);
      end
      if (wr_en_o) begin
        count_o <= count_o + (ADDR_W + 1)'(1);
      end
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader (DEPTH=4 instance so overflow is reachable).
module tb_instr_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              load_valid_i;
  logic              load_ready_o;
  logic [31:0]       load_data_i;
  logic              load_last_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              start_o;
  logic              busy_o;
  logic              overflow_o;
  logic [ADDR_W:0]   count_o;
`ifdef INSTR_LOADER_CHKSUM_EN
  logic [31:0]       chksum_i;
  logic              chksum_err_o;
`endif

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_data_i  (load_data_i),
    .load_last_i  (load_last_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .count_o      (count_o)
`ifdef INSTR_LOADER_CHKSUM_EN
    ,
    .chksum_i     (chksum_i),
    .chksum_err_o (chksum_err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog_q[$];

  // Reference model: words accepted so far, whether the loader has stopped
  // accepting, and how it should end up.
  int          acc_cnt;
  bit          done;
  bit          end_err;
  bit          end_ovf;
  logic [31:0] msum;
  int          n_writes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    acc_cnt  = 0;
    done     = 1'b0;
    end_err  = 1'b0;
    end_ovf  = 1'b0;
    msum     = '0;
    n_writes = 0;
  endtask

  // One accepted word: it goes to the next address; a last word ends the load
  // normally, a non-last word filling the final slot ends it in error.
  task automatic model_xfer(input logic [31:0] w, input bit last);
    wr_t e;
    e.addr = ADDR_W'(acc_cnt);
    e.data = w;
    exp_q.push_back(e);
    msum = msum + w;
    n_writes++;
    if (last) begin
      done = 1'b1;
`ifdef INSTR_LOADER_CHKSUM_EN
      end_err = (msum != chksum_i);
`endif
    end else if (acc_cnt == DEPTH - 1) begin
      done    = 1'b1;
      end_err = 1'b1;
      end_ovf = 1'b1;
    end
    acc_cnt++;
  endtask

  task automatic set_prog_rand(input int len);
    logic [31:0] s;
    prog_q.delete();
    s = '0;
    for (int i = 0; i < len; i++) begin
      prog_q.push_back($urandom);
      s = s + prog_q[i];
    end
`ifdef INSTR_LOADER_CHKSUM_EN
    chksum_i = s;
`endif
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", wr_addr_o, wr_data_o);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        check("wr_data", wr_data_o, e.data);
      end
    end
  end

  // Offer program words (with random idle gaps) until the model says the
  // loader stops, or n_max words have been issued. The final issued word is
  // accepted on the next rising edge after return.
  task automatic feed(input int n_max, input bit mark_last, input int gap_pct);
    int idx = 0;
    int iters = 0;
    while (idx < prog_q.size() && !done && idx < n_max) begin
      @(posedge clk); #1;
      iters++;
      if (iters > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL feed_timeout: got %0d words issued, want %0d", idx, prog_q.size());
        break;
      end
      check("load_ready", 32'(load_ready_o), 32'(!done));
      if ($urandom_range(99) < gap_pct) begin
        load_valid_i = 1'b0;
        load_data_i  = $urandom;
        load_last_i  = 1'($urandom_range(1));
      end else begin
        load_valid_i = 1'b1;
        load_data_i  = prog_q[idx];
        load_last_i  = mark_last && (idx == prog_q.size() - 1);
        model_xfer(load_data_i, load_last_i);
        idx++;
      end
    end
  endtask

  // Follow the end of a load through DRAIN/ERR into its final state.
  task automatic finish_prog();
    @(posedge clk); #1;
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    @(negedge clk);
    check("ready_n1", 32'(load_ready_o), 32'(0));
    check("start_n1", 32'(start_o), 32'(0));
    check("busy_n1", 32'(busy_o), 32'(!end_ovf));
    check("ovf_n1", 32'(overflow_o), 32'(end_ovf));
    @(negedge clk);
    check("start_n2", 32'(start_o), 32'(!end_err));
    check("busy_n2", 32'(busy_o), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      load_valid_i = 1'($urandom_range(1));
      load_data_i  = $urandom;
      load_last_i  = 1'($urandom_range(1));
    end
    @(negedge clk);
    load_valid_i = 1'b0;
    check("start_end", 32'(start_o), 32'(!end_err));
    check("ready_end", 32'(load_ready_o), 32'(0));
    check("ovf_end", 32'(overflow_o), 32'(end_ovf));
    check("count_end", 32'(count_o), 32'(n_writes));
    check("pending_writes", 32'(exp_q.size()), 32'(0));
`ifdef INSTR_LOADER_CHKSUM_EN
    check("chksum_err_end", 32'(chksum_err_o), 32'(end_err && !end_ovf));
`endif
  endtask

  // One-cycle reset, optionally with a word offered during the reset cycle.
  task automatic do_reset(input bit valid_in_reset);
    @(posedge clk); #1;
    rst_i        = 1'b0;
    load_valid_i = valid_in_reset;
    load_data_i  = $urandom;
    load_last_i  = 1'b0;
    @(posedge clk); #1;
    rst_i        = 1'b1;
    load_valid_i = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en_o), 32'(0));
    check("rst_ready", 32'(load_ready_o), 32'(1));
    check("rst_start", 32'(start_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_ovf", 32'(overflow_o), 32'(0));
    check("rst_count", 32'(count_o), 32'(0));
    check("rst_wr_addr", 32'(wr_addr_o), 32'(0));
    check("rst_pending", 32'(exp_q.size()), 32'(0));
`ifdef INSTR_LOADER_CHKSUM_EN
    check("rst_chksum_err", 32'(chksum_err_o), 32'(0));
`endif
    exp_q.delete();
    model_reset();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit mark;
    rst_i        = 1'b0;
    load_valid_i = 1'b0;
    load_data_i  = '0;
    load_last_i  = 1'b0;
`ifdef INSTR_LOADER_CHKSUM_EN
    chksum_i = '0;
`endif
    model_reset();
    do_reset(1'b0);

    // Three back-to-back instructions, last one marked.
    prog_q = '{32'h00500093, 32'h00A00113, 32'h002081B3};
`ifdef INSTR_LOADER_CHKSUM_EN
    chksum_i = 32'h00500093 + 32'h00A00113 + 32'h002081B3;
`endif
    feed(99, 1'b1, 0);
    finish_prog();
    check("basic_count", 32'(count_o), 32'(3));
    do_reset(1'b0);

    // Valid toggled with gaps.
    set_prog_rand(DEPTH);
    feed(99, 1'b1, 50);
    finish_prog();
    do_reset(1'b0);

    // Five words, none last: overflow after the fourth.
    set_prog_rand(5);
    feed(99, 1'b0, 0);
    finish_prog();
    check("ovf_start", 32'(start_o), 32'(0));
    do_reset(1'b0);

    // Exactly full: four words, last marked.
    set_prog_rand(DEPTH);
    feed(99, 1'b1, 0);
    finish_prog();
    check("full_start", 32'(start_o), 32'(1));
    do_reset(1'b0);

    // Reset after two of five words, word offered during reset, then reload.
    set_prog_rand(5);
    feed(2, 1'b1, 0);
    do_reset(1'b1);
    set_prog_rand(3);
    feed(99, 1'b1, 0);
    finish_prog();
    do_reset(1'b0);

`ifdef INSTR_LOADER_CHKSUM_EN
    // Checksum match and mismatch.
    prog_q = '{32'd1, 32'd2, 32'd3};
    chksum_i = 32'd6;
    feed(99, 1'b1, 0);
    finish_prog();
    check("chk_ok_start", 32'(start_o), 32'(1));
    do_reset(1'b0);
    prog_q = '{32'd1, 32'd2, 32'd3};
    chksum_i = 32'd7;
    feed(99, 1'b1, 0);
    finish_prog();
    check("chk_bad_err", 32'(chksum_err_o), 32'(1));
    do_reset(1'b0);
`endif

    // Randomized programs, including partial loads aborted by reset.
    for (int t = 0; t < 30; t++) begin
      mark = 1'($urandom_range(1));
      len  = mark ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(DEPTH + 1, DEPTH + 2));
      set_prog_rand(len);
`ifdef INSTR_LOADER_CHKSUM_EN
      if ($urandom_range(3) == 0) chksum_i = chksum_i + 32'd1;
`endif
      if ($urandom_range(3) == 0) begin
        feed(int'($urandom_range(0, DEPTH - 1)) < len - 1 ? int'($urandom_range(0, DEPTH - 1)) : len - 1,
             mark, 30);
        do_reset(1'b1);
      end else begin
        feed(99, mark, 30);
        finish_prog();
        do_reset(1'($urandom_range(1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
